// File: rtl/pixel_coord_generator.sv
// pixel_coord_generator
//   Walks a SCREEN_WIDTH x SCREEN_HEIGHT raster in row-major order and hands
//   each (x, y) to a downstream consumer over a valid/ready handshake.
//
//   Ports
//     clk           rising-edge clock
//     rst           synchronous active-high reset
//     start         frame request, only looked at while idle
//     coords_ready  downstream accepts the presented coordinate
//     screen_x/y    32-bit coordinate, integer part in [15:0], [31:16] zero
//     coords_valid  screen_x/screen_y carry a coordinate
//     sof/eol/eof   first pixel / last pixel of line / last pixel of frame
//     busy          frame in progress
//     frame_done    one-cycle pulse after the last pixel of a frame is taken
//     frame_count   completed frames, 16-bit wrapping
//
//   Optional feature: define CONTINUOUS_FRAME_EN to roll straight from the
//   last pixel of a frame into (0,0) of the next one with no idle gap.

`ifndef SCREEN_WIDTH
`define SCREEN_WIDTH 640
`endif
`ifndef SCREEN_HEIGHT
`define SCREEN_HEIGHT 480
`endif

module pixel_coord_generator #(
  parameter int SCREEN_WIDTH  = `SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = `SCREEN_HEIGHT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        coords_ready,
  output logic [31:0] screen_x,
  output logic [31:0] screen_y,
  output logic        coords_valid,
  output logic        sof,
  output logic        eol,
  output logic        eof,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [15:0] X_LAST = 16'(SCREEN_WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(SCREEN_HEIGHT - 1);

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        last_x, last_y, xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Valid is simply "in SCAN": the coordinate registers only move on a
  // transfer, so a stall holds them (and the flags derived from them).
  assign coords_valid = (state_q == SCAN);
  assign busy         = coords_valid;
  assign xfer         = coords_valid && coords_ready;
  assign last_x       = (x_q == X_LAST);
  assign last_y       = (y_q == Y_LAST);

  assign sof = coords_valid && (x_q == '0) && (y_q == '0);
  assign eol = coords_valid && last_x;
  assign eof = coords_valid && last_x && last_y;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = SCAN;  // counters already sit at (0,0)
      SCAN: begin
        if (xfer) begin
          if (!last_x) begin
            x_d = x_q + 16'd1;
          end else begin
            x_d = '0;
            if (!last_y) begin
              y_d = y_q + 16'd1;
            end else begin
              // Frame complete: counters return to (0,0) either for the
              // next back-to-back frame or for the next start in IDLE.
              y_d    = '0;
              done_d = 1'b1;
              cnt_d  = cnt_q + 16'd1;
`ifdef CONTINUOUS_FRAME_EN
              state_d = SCAN;
`else
              state_d = IDLE;
`endif
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign screen_x    = {16'h0, x_q};
  assign screen_y    = {16'h0, y_q};
  assign frame_done  = done_q;
  assign frame_count = cnt_q;

endmodule

// File: tb/tb_pixel_coord_generator.sv
module tb_pixel_coord_generator;
  localparam int W = 4;
  localparam int H = 3;

  logic        clk = 1'b0;
  logic        rst, start, coords_ready;
  logic [31:0] screen_x, screen_y;
  logic        coords_valid, sof, eol, eof, busy, frame_done;
  logic [15:0] frame_count;

  logic        start1, ready1;
  logic [31:0] x1, y1;
  logic        valid1, sof1, eol1, eof1, busy1, done1;
  logic [15:0] cnt1;

  always #5 clk = ~clk;

  pixel_coord_generator #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .start(start), .coords_ready(coords_ready),
    .screen_x(screen_x), .screen_y(screen_y), .coords_valid(coords_valid),
    .sof(sof), .eol(eol), .eof(eof), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count));

  pixel_coord_generator #(.SCREEN_WIDTH(1), .SCREEN_HEIGHT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .coords_ready(ready1),
    .screen_x(x1), .screen_y(y1), .coords_valid(valid1),
    .sof(sof1), .eol(eol1), .eof(eof1), .busy(busy1), .frame_done(done1),
    .frame_count(cnt1));

  typedef struct {
    logic [31:0] x, y;
    logic        sof, eol, eof;
  } coord_t;

  coord_t      q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          m_active = 1'b0;
  bit          m_done = 1'b0;
  logic [15:0] m_cnt = '0;
  bit          held = 1'b0;
  coord_t      saved;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected frame: plain raster walk with flags from their definitions.
  task automatic push_frame();
    coord_t c;
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        c.x   = 32'(xx);
        c.y   = 32'(yy);
        c.sof = (xx == 0) && (yy == 0);
        c.eol = (xx == W - 1);
        c.eof = (xx == W - 1) && (yy == H - 1);
        q.push_back(c);
      end
  endtask

  // Monitor / scoreboard: compares what the DUT shows this cycle, then
  // advances the reference model using the inputs the DUT will sample.
  always @(negedge clk) begin
    coord_t e;
    bit was_active, eof_xfer;
    if (mon_en) begin
      chk("valid", coords_valid, m_active);
      chk("busy", busy, m_active);
      chk("frame_done", frame_done, m_done);
      chk("frame_count", frame_count, m_cnt);
      if (!coords_valid) chk("flags_idle", {sof, eol, eof}, 3'b000);
      if (held) begin
        chk("stall_x", screen_x, saved.x);
        chk("stall_y", screen_y, saved.y);
        chk("stall_flags", {sof, eol, eof}, {saved.sof, saved.eol, saved.eof});
      end
    end
    held = 1'b0;
    eof_xfer = 1'b0;
    was_active = m_active;
    if (rst) begin
      q.delete();
      m_active = 1'b0;
      m_done = 1'b0;
      m_cnt = '0;
    end else if (mon_en) begin
      if (coords_valid && coords_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_xfer: got (%0d,%0d) expected none", screen_x, screen_y);
        end else begin
          e = q.pop_front();
          chk("x", screen_x, e.x);
          chk("y", screen_y, e.y);
          chk("sof", sof, e.sof);
          chk("eol", eol, e.eol);
          chk("eof", eof, e.eof);
          eof_xfer = e.eof;
        end
      end else if (coords_valid) begin
        held = 1'b1;
        saved.x = screen_x; saved.y = screen_y;
        saved.sof = sof; saved.eol = eol; saved.eof = eof;
      end
      m_done = eof_xfer;
      if (eof_xfer) begin
        m_cnt++;
`ifdef CONTINUOUS_FRAME_EN
        push_frame();
`else
        m_active = 1'b0;
`endif
      end
      if (!was_active && start) begin
        m_active = 1'b1;
        push_frame();
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit hit;
    rst = 1'b1; start = 1'b0; coords_ready = 1'b0; start1 = 1'b0; ready1 = 1'b0;
    cyc(2);
    // Reset values, including ones the monitor does not track.
    chk("rst_x", screen_x, 32'h0);
    chk("rst_y", screen_y, 32'h0);
    chk("rst_valid", coords_valid, 1'b0);
    chk("rst_count", frame_count, 16'h0);
    rst = 1'b0; mon_en = 1'b1;

    // Reset mid-frame at (2,1) with start and ready also high.
    coords_ready = 1'b1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (coords_valid && screen_x == 32'd2 && screen_y == 32'd1) hit = 1'b1;
      else cyc(1);
    end
    chk("reach_2_1", hit, 1'b1);
    rst = 1'b1; start = 1'b1;
    cyc(1);
    rst = 1'b0; start = 1'b0;
    cyc(2);

    // Full frame, ready held high.
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(20);

    // Random ready and random (ignored while scanning) start.
    for (int i = 0; i < 200; i++) begin
      coords_ready = $urandom_range(0, 1) == 1;
      start = $urandom_range(0, 7) == 0;
      cyc(1);
    end
    start = 1'b0;

    // Start held high through consecutive frames, ready high.
    coords_ready = 1'b1; start = 1'b1;
    cyc(40);
    start = 1'b0;
    cyc(15);

    // 1x1 screen on the second instance.
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    start1 = 1'b1; ready1 = 1'b1;
    @(negedge clk);
    chk("w1_idle_valid", valid1, 1'b0);
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    chk("w1_valid", valid1, 1'b1);
    chk("w1_xy", {x1, y1}, 64'h0);
    chk("w1_flags", {sof1, eol1, eof1}, 3'b111);
    @(negedge clk);
    chk("w1_done", done1, 1'b1);
    chk("w1_count", cnt1, 16'd1);
`ifdef CONTINUOUS_FRAME_EN
    chk("w1_valid_after", valid1, 1'b1);
`else
    chk("w1_valid_after", valid1, 1'b0);
`endif
    @(negedge clk);
    chk("w1_done_pulse", done1, 1'b0);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
